// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue/result front end.
// Holds the default datapath widths, the ALU op encodings driven on
// io_alu_sw and the operand-select encodings seen on io_in_asel/io_in_bsel.
package alu_issue_stage_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int REG_IDX_W_DEF = 5;
    localparam int OVF_CNT_W_DEF = 16;

    // Op codes understood by the downstream ALU; 5..7 make it output zero.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    // Operand A source; 3 behaves like ASEL_ZERO.
    localparam logic [1:0] ASEL_SRC1 = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;

    // Operand B source.
    localparam logic BSEL_SRC2 = 1'b0;
    localparam logic BSEL_IMM  = 1'b1;

endpackage

// File: rtl/alu_issue_stage_alu_fwd_mux.sv
// alu_fwd_mux: priority operand forwarding for one source register.
// Ports:
//   rs                      source register index of the incoming op
//   raw                     register-file read value for rs
//   s1_valid/s1_wen/s1_rd   issue-stage occupant; s1_data is the live ALU result
//   s2_valid/s2_wen/s2_rd   result-stage occupant; s2_data is its stored result
//   data                    selected operand value
// The younger op (S1) wins over the older one (S2); index 0 never forwards.
module alu_fwd_mux
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [XLEN-1:0]      raw,
    input  logic                 s1_valid,
    input  logic                 s1_wen,
    input  logic [REG_IDX_W-1:0] s1_rd,
    input  logic [XLEN-1:0]      s1_data,
    input  logic                 s2_valid,
    input  logic                 s2_wen,
    input  logic [REG_IDX_W-1:0] s2_rd,
    input  logic [XLEN-1:0]      s2_data,
    output logic [XLEN-1:0]      data
);

    function automatic logic rd_match(input logic                 valid,
                                      input logic                 wen,
                                      input logic [REG_IDX_W-1:0] rd,
                                      input logic [REG_IDX_W-1:0] src);
        return valid && wen && (rd != {REG_IDX_W{1'b0}}) && (rd == src);
    endfunction

    logic s1_hit_s;
    logic s2_hit_s;

    assign s1_hit_s = rd_match(s1_valid, s1_wen, s1_rd, rs);
    assign s2_hit_s = rd_match(s2_valid, s2_wen, s2_rd, rs);

    // Pick the youngest in-flight producer of rs, else the register file.
    always_comb begin
        data = raw;
        if (s1_hit_s) begin
            data = s1_data;
        end else if (s2_hit_s) begin
            data = s2_data;
        end else begin
            data = raw;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage execute front end around a combinational ALU.
// Ports:
//   clock, reset (async, active-high), io_flush (sync kill of S1 and S2)
//   io_in_*    decoded op with valid/ready handshake
//   io_alu_*   S1 operands/op out to the ALU, ALU result and flags back in
//   io_out_*   S2 result with valid/ready handshake toward MEM/WB
//   io_cnt_issued  wrapping count of S1->S2 transfers
//   io_cnt_ovf     saturating count of transfers carrying overflow
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int OVF_CNT_W = OVF_CNT_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_flush,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [XLEN-1:0]      io_in_src1,
    input  logic [XLEN-1:0]      io_in_src2,
    input  logic [XLEN-1:0]      io_in_pc,
    input  logic [XLEN-1:0]      io_in_imm,
    input  logic [1:0]           io_in_asel,
    input  logic                 io_in_bsel,
    input  logic [2:0]           io_in_sw,
    input  logic [REG_IDX_W-1:0] io_in_rs1,
    input  logic [REG_IDX_W-1:0] io_in_rs2,
    input  logic [REG_IDX_W-1:0] io_in_rd,
    input  logic                 io_in_wen,
    output logic [XLEN-1:0]      io_alu_a,
    output logic [XLEN-1:0]      io_alu_b,
    output logic [2:0]           io_alu_sw,
    input  logic [XLEN-1:0]      io_alu_out,
    input  logic                 io_alu_carry,
    input  logic                 io_alu_overflow,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [XLEN-1:0]      io_out_result,
    output logic [REG_IDX_W-1:0] io_out_rd,
    output logic                 io_out_wen,
    output logic                 io_out_carry,
    output logic                 io_out_overflow,
    output logic [31:0]          io_cnt_issued,
    output logic [OVF_CNT_W-1:0] io_cnt_ovf
);

    // Issue stage (S1) state; payload drives the ALU directly.
    logic                 s1_valid_r;
    logic [XLEN-1:0]      s1_a_r;
    logic [XLEN-1:0]      s1_b_r;
    logic [2:0]           s1_sw_r;
    logic [REG_IDX_W-1:0] s1_rd_r;
    logic                 s1_wen_r;
    // Result stage (S2) state.
    logic                 s2_valid_r;
    logic [XLEN-1:0]      s2_result_r;
    logic [REG_IDX_W-1:0] s2_rd_r;
    logic                 s2_wen_r;
    logic                 s2_carry_r;
    logic                 s2_ovf_r;
    // Event counters.
    logic [31:0]          cnt_issued_r;
    logic [OVF_CNT_W-1:0] cnt_ovf_r;
    // Flow control and operand selection.
    logic                 s2_free_s;
    logic                 s1_adv_s;
    logic                 accept_s;
    logic [XLEN-1:0]      fwd_a_s;
    logic [XLEN-1:0]      fwd_b_s;
    logic [XLEN-1:0]      op_a_s;
    logic [XLEN-1:0]      op_b_s;

    assign s2_free_s   = !s2_valid_r || io_out_ready;
    assign s1_adv_s    = s1_valid_r && s2_free_s;
    assign io_in_ready = !io_flush && (!s1_valid_r || s2_free_s);
    assign accept_s    = io_in_valid && io_in_ready;

    alu_fwd_mux #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd_a (
        .rs(io_in_rs1), .raw(io_in_src1),
        .s1_valid(s1_valid_r), .s1_wen(s1_wen_r), .s1_rd(s1_rd_r), .s1_data(io_alu_out),
        .s2_valid(s2_valid_r), .s2_wen(s2_wen_r), .s2_rd(s2_rd_r), .s2_data(s2_result_r),
        .data(fwd_a_s)
    );

    alu_fwd_mux #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd_b (
        .rs(io_in_rs2), .raw(io_in_src2),
        .s1_valid(s1_valid_r), .s1_wen(s1_wen_r), .s1_rd(s1_rd_r), .s1_data(io_alu_out),
        .s2_valid(s2_valid_r), .s2_wen(s2_wen_r), .s2_rd(s2_rd_r), .s2_data(s2_result_r),
        .data(fwd_b_s)
    );

    // Operand A/B selection; pc, imm and zero bypass forwarding.
    always_comb begin
        op_a_s = {XLEN{1'b0}};
        op_b_s = fwd_b_s;
        case (io_in_asel)
            ASEL_SRC1: op_a_s = fwd_a_s;
            ASEL_PC:   op_a_s = io_in_pc;
            default:   op_a_s = {XLEN{1'b0}};
        endcase
        if (io_in_bsel == BSEL_IMM) begin
            op_b_s = io_in_imm;
        end else begin
            op_b_s = fwd_b_s;
        end
    end

    // S1 register: load on accept, drain on advance, kill on flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {XLEN{1'b0}};
            s1_b_r     <= {XLEN{1'b0}};
            s1_sw_r    <= 3'd0;
            s1_rd_r    <= {REG_IDX_W{1'b0}};
            s1_wen_r   <= 1'b0;
        end else if (io_flush) begin
            s1_valid_r <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= op_a_s;
            s1_b_r     <= op_b_s;
            s1_sw_r    <= io_in_sw;
            s1_rd_r    <= io_in_rd;
            s1_wen_r   <= io_in_wen;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S2 register: capture ALU result on advance, clear when consumed alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= {XLEN{1'b0}};
            s2_rd_r     <= {REG_IDX_W{1'b0}};
            s2_wen_r    <= 1'b0;
            s2_carry_r  <= 1'b0;
            s2_ovf_r    <= 1'b0;
        end else if (io_flush) begin
            s2_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_r  <= 1'b1;
            s2_result_r <= io_alu_out;
            s2_rd_r     <= s1_rd_r;
            s2_wen_r    <= s1_wen_r;
            s2_carry_r  <= io_alu_carry;
            s2_ovf_r    <= io_alu_overflow;
        end else if (io_out_ready) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Counters: issued wraps, overflow saturates; killed ops are not counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_issued_r <= 32'd0;
            cnt_ovf_r    <= {OVF_CNT_W{1'b0}};
        end else if (!io_flush && s1_adv_s) begin
            cnt_issued_r <= cnt_issued_r + 32'd1;
            if (io_alu_overflow && (cnt_ovf_r != {OVF_CNT_W{1'b1}})) begin
                cnt_ovf_r <= cnt_ovf_r + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign io_alu_a        = s1_a_r;
    assign io_alu_b        = s1_b_r;
    assign io_alu_sw       = s1_sw_r;
    assign io_out_valid    = s2_valid_r;
    assign io_out_result   = s2_result_r;
    assign io_out_rd       = s2_rd_r;
    assign io_out_wen      = s2_wen_r;
    assign io_out_carry    = s2_carry_r;
    assign io_out_overflow = s2_ovf_r;
    assign io_cnt_issued   = cnt_issued_r;
    assign io_cnt_ovf      = cnt_ovf_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: a behavioural ALU closes the loop, a
// scoreboard queue holds expected results pushed at issue, and a monitor
// pops and compares whenever the DUT hands a result downstream.
// The overflow counter is built 4 bits wide so saturation is reached quickly.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    localparam int XW = 32;
    localparam int RW = 5;
    localparam int OW = 4;

    logic clock, reset, io_flush, io_in_valid, io_in_ready, io_in_bsel, io_in_wen;
    logic [XW-1:0] io_in_src1, io_in_src2, io_in_pc, io_in_imm;
    logic [1:0] io_in_asel;
    logic [2:0] io_in_sw, io_alu_sw;
    logic [RW-1:0] io_in_rs1, io_in_rs2, io_in_rd, io_out_rd;
    logic [XW-1:0] io_alu_a, io_alu_b, io_alu_out, io_out_result;
    logic io_alu_carry, io_alu_overflow, io_out_valid, io_out_ready;
    logic io_out_wen, io_out_carry, io_out_overflow;
    logic [31:0] io_cnt_issued;
    logic [OW-1:0] io_cnt_ovf;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
        logic        c;
        logic        o;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int n_cmp = 0;
    int n_fail = 0;
    int exp_issued = 0;
    logic [32:0] sum33;

    alu_issue_stage #(.XLEN(XW), .REG_IDX_W(RW), .OVF_CNT_W(OW)) dut (
        .clock(clock), .reset(reset), .io_flush(io_flush),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_src1(io_in_src1), .io_in_src2(io_in_src2),
        .io_in_pc(io_in_pc), .io_in_imm(io_in_imm),
        .io_in_asel(io_in_asel), .io_in_bsel(io_in_bsel), .io_in_sw(io_in_sw),
        .io_in_rs1(io_in_rs1), .io_in_rs2(io_in_rs2), .io_in_rd(io_in_rd),
        .io_in_wen(io_in_wen),
        .io_alu_a(io_alu_a), .io_alu_b(io_alu_b), .io_alu_sw(io_alu_sw),
        .io_alu_out(io_alu_out), .io_alu_carry(io_alu_carry),
        .io_alu_overflow(io_alu_overflow),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_result(io_out_result), .io_out_rd(io_out_rd),
        .io_out_wen(io_out_wen), .io_out_carry(io_out_carry),
        .io_out_overflow(io_out_overflow),
        .io_cnt_issued(io_cnt_issued), .io_cnt_ovf(io_cnt_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural 32-bit ALU; carry of sub is the carry-out of a + ~b + 1.
    always_comb begin
        sum33 = 33'd0;
        io_alu_out = 32'd0;
        io_alu_carry = 1'b0;
        io_alu_overflow = 1'b0;
        case (io_alu_sw)
            3'd0: begin
                sum33 = {1'b0, io_alu_a} + {1'b0, io_alu_b};
                io_alu_out = sum33[31:0];
                io_alu_carry = sum33[32];
                io_alu_overflow = (io_alu_a[31] == io_alu_b[31]) && (sum33[31] != io_alu_a[31]);
            end
            3'd1: begin
                sum33 = {1'b0, io_alu_a} + {1'b0, ~io_alu_b} + 33'd1;
                io_alu_out = sum33[31:0];
                io_alu_carry = sum33[32];
                io_alu_overflow = (io_alu_a[31] != io_alu_b[31]) && (sum33[31] != io_alu_a[31]);
            end
            3'd2: io_alu_out = io_alu_a & io_alu_b;
            3'd3: io_alu_out = io_alu_a | io_alu_b;
            3'd4: io_alu_out = io_alu_a ^ io_alu_b;
            default: io_alu_out = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one op from a negedge until accepted; returns on the following negedge.
    task automatic send(input logic [31:0] s1v, input logic [31:0] s2v,
                        input logic [31:0] pcv, input logic [31:0] immv,
                        input logic [1:0] asel, input logic bsel, input logic [2:0] sw,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wen,
                        input logic [31:0] eres, input logic ec, input logic eo,
                        input bit push);
        int waited;
        exp_t e;
        waited = 0;
        io_in_valid = 1'b1;
        io_in_src1 = s1v; io_in_src2 = s2v; io_in_pc = pcv; io_in_imm = immv;
        io_in_asel = asel; io_in_bsel = bsel; io_in_sw = sw;
        io_in_rs1 = rs1; io_in_rs2 = rs2; io_in_rd = rd; io_in_wen = wen;
        #1;
        while (!io_in_ready && waited < 40) begin
            @(negedge clock); #1;
            waited++;
        end
        if (!io_in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 at %0t", $time);
            io_in_valid = 1'b0;
        end else begin
            if (push) begin
                e.res = eres; e.rd = rd; e.wen = wen; e.c = ec; e.o = eo;
                sb_q.push_back(e);
                exp_issued++;
            end
            @(negedge clock);
            io_in_valid = 1'b0;
        end
    endtask

    // Register-register op with no forwarding candidates (rs1=rs2=0).
    task automatic op_rr(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sw,
                         input logic [4:0] rd, input logic [31:0] eres,
                         input logic ec, input logic eo);
        send(a, b, 32'd0, 32'd0, ASEL_SRC1, BSEL_SRC2, sw, 5'd0, 5'd0, rd, 1'b1, eres, ec, eo, 1'b1);
    endtask

    // Monitor: pop and compare each result the DUT hands downstream.
    always begin
        @(negedge clock); #2;
        if (!reset && io_out_valid && io_out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_output: got result 0x%0h expected no output", io_out_result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_result", io_out_result, mon_e.res);
                chk("out_rd", {27'd0, io_out_rd}, {27'd0, mon_e.rd});
                chk("out_wen", {31'd0, io_out_wen}, {31'd0, mon_e.wen});
                chk("out_carry", {31'd0, io_out_carry}, {31'd0, mon_e.c});
                chk("out_overflow", {31'd0, io_out_overflow}, {31'd0, mon_e.o});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; io_flush = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b1;
        io_in_src1 = 32'd0; io_in_src2 = 32'd0; io_in_pc = 32'd0; io_in_imm = 32'd0;
        io_in_asel = 2'd0; io_in_bsel = 1'b0; io_in_sw = 3'd0;
        io_in_rs1 = 5'd0; io_in_rs2 = 5'd0; io_in_rd = 5'd0; io_in_wen = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("rst_alu_a", io_alu_a, 32'd0);
        chk("rst_alu_b", io_alu_b, 32'd0);
        chk("rst_alu_sw", {29'd0, io_alu_sw}, 32'd0);
        chk("rst_out_result", io_out_result, 32'd0);
        chk("rst_cnt_issued", io_cnt_issued, 32'd0);
        chk("rst_cnt_ovf", {28'd0, io_cnt_ovf}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // First op: 5 + 3 visible two cycles after acceptance.
        send(32'd5, 32'd3, 32'd0, 32'd0, ASEL_SRC1, BSEL_SRC2, 3'd0, 5'd2, 5'd3, 5'd4, 1'b1,
             32'd8, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        chk("first_out_valid", {31'd0, io_out_valid}, 32'd1);
        chk("first_cnt_issued", io_cnt_issued, 32'd1);

        // Forward from S1 (back-to-back dependent op).
        op_rr(32'h10, 32'h20, 3'd0, 5'd1, 32'h30, 1'b0, 1'b0);
        send(32'hDEAD, 32'd0, 32'd0, 32'd1, ASEL_SRC1, BSEL_IMM, 3'd0, 5'd1, 5'd0, 5'd5, 1'b1,
             32'h31, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        // Forward from S2 (one-cycle bubble).
        op_rr(32'h10, 32'h20, 3'd0, 5'd1, 32'h30, 1'b0, 1'b0);
        @(negedge clock);
        send(32'hDEAD, 32'd0, 32'd0, 32'd1, ASEL_SRC1, BSEL_IMM, 3'd0, 5'd1, 5'd0, 5'd5, 1'b1,
             32'h31, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        // rd=0 never forwards: stale register value is used.
        op_rr(32'h10, 32'h20, 3'd0, 5'd0, 32'h30, 1'b0, 1'b0);
        send(32'hDEAD, 32'd0, 32'd0, 32'd1, ASEL_SRC1, BSEL_IMM, 3'd0, 5'd0, 5'd0, 5'd5, 1'b1,
             32'hDEAE, 1'b0, 1'b0, 1'b1);
        // Other ops and operand selections.
        op_rr(32'd5, 32'd7, 3'd1, 5'd6, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op_rr(32'hF0F0, 32'hFF00, 3'd2, 5'd6, 32'hF000, 1'b0, 1'b0);
        send(32'd0, 32'd0, 32'h1000, 32'h24, ASEL_PC, BSEL_IMM, 3'd3, 5'd0, 5'd0, 5'd6, 1'b1,
             32'h1024, 1'b0, 1'b0, 1'b1);
        send(32'h77, 32'h55, 32'd0, 32'd0, ASEL_ZERO, BSEL_SRC2, 3'd4, 5'd0, 5'd0, 5'd6, 1'b0,
             32'h55, 1'b0, 1'b0, 1'b1);
        op_rr(32'd1, 32'd2, 3'd6, 5'd6, 32'd0, 1'b0, 1'b0);
        // S1 forwarding has priority over S2 for the same rd.
        op_rr(32'd1, 32'd1, 3'd0, 5'd7, 32'd2, 1'b0, 1'b0);
        op_rr(32'd3, 32'd3, 3'd0, 5'd7, 32'd6, 1'b0, 1'b0);
        send(32'h10, 32'hBAD, 32'd0, 32'd0, ASEL_SRC1, BSEL_SRC2, 3'd0, 5'd0, 5'd7, 5'd11, 1'b1,
             32'h16, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);

        // Overflow counting and saturation (4-bit counter saturates at 15).
        op_rr(32'h7FFF_FFFF, 32'd1, 3'd0, 5'd12, 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clock);
        chk("ovf_cnt_one", {28'd0, io_cnt_ovf}, 32'd1);
        op_rr(32'h8000_0000, 32'd1, 3'd1, 5'd12, 32'h7FFF_FFFF, 1'b1, 1'b1);
        @(negedge clock);
        chk("ovf_cnt_two", {28'd0, io_cnt_ovf}, 32'd2);
        for (int i = 0; i < 14; i++) begin
            op_rr(32'h7FFF_FFFF, 32'd1, 3'd0, 5'd12, 32'h8000_0000, 1'b0, 1'b1);
        end
        repeat (2) @(negedge clock);
        chk("ovf_cnt_sat", {28'd0, io_cnt_ovf}, 32'd15);
        chk("issued_after_ovf", io_cnt_issued, exp_issued);

        // Backpressure: downstream stalls for 4 cycles with 3 ops offered.
        io_out_ready = 1'b0;
        fork
            begin
                op_rr(32'd1, 32'd1, 3'd0, 5'd8, 32'd2, 1'b0, 1'b0);
                op_rr(32'h100, 32'h200, 3'd0, 5'd9, 32'h300, 1'b0, 1'b0);
                op_rr(32'hF0, 32'hFF, 3'd4, 5'd10, 32'h0F, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(negedge clock);
                #1;
                chk("bp_ready_c3", {31'd0, io_in_ready}, 32'd0);
                chk("bp_out_valid_c3", {31'd0, io_out_valid}, 32'd1);
                chk("bp_out_result_c3", io_out_result, 32'd2);
                @(negedge clock); #1;
                chk("bp_ready_c4", {31'd0, io_in_ready}, 32'd0);
                chk("bp_alu_a_hold", io_alu_a, 32'h100);
                chk("bp_alu_b_hold", io_alu_b, 32'h200);
                @(negedge clock);
                io_out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clock);
        chk("bp_issued", io_cnt_issued, exp_issued);
        chk("bp_queue_drained", sb_q.size(), 32'd0);

        // Flush with S1 and S2 both full and a new op offered.
        io_out_ready = 1'b0;
        op_rr(32'd9, 32'd9, 3'd0, 5'd13, 32'd18, 1'b0, 1'b0);
        void'(sb_q.pop_back()); exp_issued--;
        op_rr(32'd4, 32'd4, 3'd0, 5'd14, 32'd8, 1'b0, 1'b0);
        void'(sb_q.pop_back()); exp_issued--;
        exp_issued++;  // first of the two did reach S2
        chk("pre_flush_out_valid", {31'd0, io_out_valid}, 32'd1);
        io_flush = 1'b1;
        io_in_valid = 1'b1; io_in_asel = ASEL_SRC1; io_in_bsel = BSEL_SRC2;
        io_in_src1 = 32'd1; io_in_src2 = 32'd1; io_in_rs1 = 5'd0; io_in_rs2 = 5'd0;
        #1;
        chk("flush_in_ready", {31'd0, io_in_ready}, 32'd0);
        @(negedge clock);
        io_flush = 1'b0; io_in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("flush_cnt_issued", io_cnt_issued, exp_issued);
        io_out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("flush_no_late_output", {31'd0, io_out_valid}, 32'd0);

        // Asynchronous reset between edges while S2 holds a result.
        io_out_ready = 1'b0;
        send(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, ASEL_SRC1, BSEL_SRC2, 3'd0, 5'd0, 5'd0, 5'd15,
             1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        chk("pre_reset_out_valid", {31'd0, io_out_valid}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("async_rst_cnt_issued", io_cnt_issued, 32'd0);
        chk("async_rst_cnt_ovf", {28'd0, io_cnt_ovf}, 32'd0);
        chk("async_rst_alu_a", io_alu_a, 32'd0);
        chk("async_rst_out_result", io_out_result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        io_out_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("end_queue_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
